// File: rtl/add_pkg.sv
// Shared helpers for the pipelined adder/subtractor: chunk sizing, configuration check, overflow rule.
package add_pkg;

    function automatic int unsigned chunk_width(input int unsigned n, input int unsigned stages);
        return n / stages;
    endfunction

    function automatic bit stages_ok(input int unsigned n, input int unsigned stages);
        return (n >= 2) && (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Registered W-bit adder slice: partial sum, carry, running zero and top-slice overflow flag.
module add_chunk
    import add_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    input  logic         z_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         z_o,
    output logic         ovf_o
);

    localparam int unsigned WX = W + 1;

    logic [W:0]   total_d;
    logic [W-1:0] sum_q;
    logic         cout_q;
    logic         z_q;
    logic         ovf_q;

    assign total_d = WX'(a_i) + WX'(b_i) + WX'(c_i);

    // z_i carries "all lower slices were zero", so the top slice ends up with the full-width flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            z_q    <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en_i) begin
            sum_q  <= total_d[W-1:0];
            cout_q <= total_d[W];
            z_q    <= z_i && (total_d[W-1:0] == '0);
            ovf_q  <= ovf_flag(a_i[W-1], b_i[W-1], total_d[W-1]);
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign z_o    = z_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/pipelined_add_sub.sv
// N-bit adder/subtractor with the carry chain split over STAGES registered chunks and valid/ready flow control.
module pipelined_add_sub
    import add_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int unsigned CH = chunk_width(N, STAGES);

    if (!stages_ok(N, STAGES)) begin : g_bad_cfg
        $error("pipelined_add_sub: need N >= 2, 1 <= STAGES <= N and N divisible by STAGES");
    end

    logic                      advance;
    logic [N-1:0]              b_eff;
    logic                      c0;
    logic [STAGES-1:0]         vld_q;
    logic [N-1:0]              a_sk_q [STAGES];
    logic [N-1:0]              b_sk_q [STAGES];
    logic [N-1:0]              dsk_q  [STAGES];
    logic [N-1:0]              dsk_d  [STAGES];
    logic [N-1:0]              sum_full;
    logic [STAGES-1:0][CH-1:0] chunk_a;
    logic [STAGES-1:0][CH-1:0] chunk_b;
    logic [STAGES-1:0][CH-1:0] chunk_sum;
    logic [STAGES-1:0]         chunk_cin;
    logic [STAGES-1:0]         chunk_cout;
    logic [STAGES-1:0]         chunk_zin;
    logic [STAGES-1:0]         chunk_z;
    logic [STAGES-1:0]         chunk_ovf;
    logic                      unused_lower_ovf;

    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub ? ~cin : cin;

    // Stage s sees chunk s of the operands after s skew registers, aligned with the carry from stage s-1.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign chunk_a[s]   = a[CH-1:0];
            assign chunk_b[s]   = b_eff[CH-1:0];
            assign chunk_cin[s] = c0;
            assign chunk_zin[s] = 1'b1;
        end else begin : g_next
            assign chunk_a[s]   = a_sk_q[s-1][s*CH +: CH];
            assign chunk_b[s]   = b_sk_q[s-1][s*CH +: CH];
            assign chunk_cin[s] = chunk_cout[s-1];
            assign chunk_zin[s] = chunk_z[s-1];
        end

        add_chunk #(
            .W (CH)
        ) u_chunk (
            .clk    (clk),
            .rst    (rst),
            .en_i   (advance),
            .a_i    (chunk_a[s]),
            .b_i    (chunk_b[s]),
            .c_i    (chunk_cin[s]),
            .z_i    (chunk_zin[s]),
            .sum_o  (chunk_sum[s]),
            .cout_o (chunk_cout[s]),
            .z_o    (chunk_z[s]),
            .ovf_o  (chunk_ovf[s])
        );
    end

    // Deskew: dsk_q[s] holds finished chunks 0..s-1 in step with stage s.
    always_comb begin
        dsk_d[0] = '0;
        for (int s = 1; s < STAGES; s++) begin
            dsk_d[s]                   = dsk_q[s-1];
            dsk_d[s][(s-1)*CH +: CH]   = chunk_sum[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                a_sk_q[s] <= '0;
                b_sk_q[s] <= '0;
                dsk_q[s]  <= '0;
            end
        end else if (advance) begin
            vld_q[0]  <= in_valid;
            a_sk_q[0] <= a;
            b_sk_q[0] <= b_eff;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s]  <= vld_q[s-1];
                a_sk_q[s] <= a_sk_q[s-1];
                b_sk_q[s] <= b_sk_q[s-1];
            end
            for (int s = 0; s < STAGES; s++) begin
                dsk_q[s] <= dsk_d[s];
            end
        end
    end

    always_comb begin
        sum_full                            = dsk_q[STAGES-1];
        sum_full[(STAGES-1)*CH +: CH]       = chunk_sum[STAGES-1];
    end

    // Only the top slice's overflow is meaningful; lower slices' flags are folded away.
    assign unused_lower_ovf = ^chunk_ovf;

    assign sum       = sum_full;
    assign out_valid = vld_q[STAGES-1];
    assign cout      = chunk_cout[STAGES-1];
    assign ovf       = chunk_ovf[STAGES-1];
    assign zero      = chunk_z[STAGES-1];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench: directed and random operations scored against an arithmetic reference model.
module tb_pipelined_add_sub;

    localparam int unsigned N = 16;
    localparam int unsigned S = 4;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [N-1:0] a, b, sum;
    logic         in_valid8, in_ready8, out_valid8, cout8, ovf8, zero8;
    logic [7:0]   a8, b8, sum8;

    pipelined_add_sub #(.N(N), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_add_sub #(.N(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin), .sub(sub),
        .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    res_t         exp_q[$];
    int           acc_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           lat_on = 1'b0;
    bit           prev_stall = 1'b0;
    logic [N-1:0] prev_sum;
    logic         prev_cout, prev_ovf, prev_zero;

    // Reference: plain integer arithmetic on w-bit unsigned and signed interpretations.
    function automatic res_t model(input int unsigned w, input logic [N-1:0] x, input logic [N-1:0] y,
                                   input logic ci, input logic sb);
        longint m  = longint'(1) << w;
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint c  = ci ? 64'sd1 : 64'sd0;
        longint sx, sy, raw, sraw, s;
        res_t   r;
        sx     = (ux >= m / 2) ? ux - m : ux;
        sy     = (uy >= m / 2) ? uy - m : uy;
        raw    = sb ? ux - uy - c : ux + uy + c;
        sraw   = sb ? sx - sy - c : sx + sy + c;
        s      = ((raw % m) + m) % m;
        r.sum  = N'(s);
        r.cout = sb ? (raw >= 0) : (raw >= m);
        r.ovf  = (sraw < -(m / 2)) || (sraw >= m / 2);
        r.zero = (s == 0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, expv);
        end
    endtask

    // One clock: score handshakes at the falling edge, then let the rising edge act.
    task automatic step();
        res_t e;
        int   lat;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum",   32'(sum),       32'(prev_sum));
                chk("hold_cout",  32'(cout),      32'(prev_cout));
                chk("hold_ovf",   32'(ovf),       32'(prev_ovf));
                chk("hold_zero",  32'(zero),      32'(prev_zero));
            end
            if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e   = exp_q.pop_front();
                    lat = cyc - acc_q.pop_front();
                    chk("sum",  32'(sum),  32'(e.sum));
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("ovf",  32'(ovf),  32'(e.ovf));
                    chk("zero", 32'(zero), 32'(e.zero));
                    if (lat_on) chk("latency", 32'(lat), 32'(S));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(N, a, b, cin, sub));
                acc_q.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_cout  = cout;
            prev_ovf   = ovf;
            prev_zero  = zero;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_wait(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci, input logic sb);
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        chk("send_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        drain("drain_directed");
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sb);
        res_t e;
        e = model(8, N'(x), N'(y), ci, sb);
        a8 = x; b8 = y; cin = ci; sub = sb; in_valid8 = 1'b1;
        @(negedge clk);
        chk("w8_pre_valid", 32'(out_valid8), 32'd0);
        chk("w8_in_ready",  32'(in_ready8),  32'd1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        chk("w8_valid", 32'(out_valid8), 32'd1);
        chk("w8_sum",   32'(sum8),       32'(e.sum[7:0]));
        chk("w8_cout",  32'(cout8),      32'(e.cout));
        chk("w8_ovf",   32'(ovf8),       32'(e.ovf));
        chk("w8_zero",  32'(zero8),      32'(e.zero));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w8_single", 32'(out_valid8), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",  32'(out_valid),  32'd0);
        chk("rst_sum",    32'(sum),        32'd0);
        chk("rst_cout",   32'(cout),       32'd0);
        chk("rst_ovf",    32'(ovf),        32'd0);
        chk("rst_zero",   32'(zero),       32'd0);
        chk("rst_valid8", 32'(out_valid8), 32'd0);
        chk("rst_sum8",   32'(sum8),       32'd0);
        rst = 1'b0;

        // Directed corner cases with a free-running sink.
        lat_on = 1'b1;
        send_wait(16'h0001, 16'h0002, 1'b0, 1'b0);
        send_wait(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send_wait(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send_wait(16'h0005, 16'h0007, 1'b0, 1'b1);
        send_wait(16'h000A, 16'h0003, 1'b1, 1'b1);
        send_wait(16'h8000, 16'h0001, 1'b0, 1'b1);

        // Eleven back-to-back operations.
        for (int k = 1; k <= 11; k++) begin
            a = N'(k); b = N'(k + 1); cin = (k > 5); sub = 1'b0; in_valid = 1'b1;
            step();
        end
        drain("drain_stream");

        // Backpressure window while streaming.
        lat_on = 1'b0;
        for (int i = 0; i < 14; i++) begin
            a = N'($urandom); b = N'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid  = 1'b1;
            out_ready = !(i >= 5 && i < 10);
            step();
        end
        drain("drain_backpressure");

        // Random traffic with random stalls.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            a = N'($urandom); b = N'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            step();
        end
        drain("drain_random");

        // Reset with three operations in flight.
        lat_on = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = N'(100 + k); b = N'(k); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
        end
        send_wait(16'h1234, 16'h4321, 1'b1, 1'b0);

        // Single-stage 8-bit instance.
        op8(8'h01, 8'h02, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        op8(8'h05, 8'h07, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
Parameterised N-bit adder/subtractor, the registered successor to the team's combinational full adder. The carry chain is split into STAGES equal chunks with one register boundary per chunk, so wide adds close timing at high clock rates. A valid/ready handshake with backpressure lets it sit directly in streaming datapaths. It also produces signed-overflow and zero flags.

Parameters:
N, 16, operand and result width in bits; N >= 2.
STAGES, 4, number of pipeline stages and carry-chain chunks; 1 <= STAGES <= N; N % STAGES == 0 (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand set presented
in_ready  output  1  block accepts operands this cycle
a  input  N  operand A, unsigned or two's complement
b  input  N  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = a+b+cin, 1 = a-b-cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  N  result
cout  output  1  carry-out of the N-bit adder (sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow
zero  output  1  sum == 0

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst; all state updates only on rising clk.
- Reset: every stage valid bit cleared; out_valid=0, sum=0, cout=0, ovf=0, zero=0. Asserting rst mid-operation discards all in-flight results; none emerge afterwards.
- Operand conditioning at input: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin. The sum is always a + b_eff + c0, N bits, and cout is carry out of bit N-1.
- Chunking: CH = N/STAGES. Stage k (0..STAGES-1) adds chunk k of a and b_eff plus the carry registered by stage k-1 (c0 for k=0) and registers the CH-bit partial sum and carry.
- Skew: upper operand chunks are delayed through skew registers until their stage. Lower result chunks are delayed through deskew registers so all N sum bits align at the output.
- Latency: exactly STAGES cycles from accept (in_valid && in_ready) to out_valid, with no stall. STAGES=1 gives a single register after a full-width add.
- Flags: computed on the final stage from the aligned MSBs of a and b_eff. ovf = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]); zero = (sum == 0). Both are registered with sum.
- Handshake: advance = out_ready || !out_valid, and in_ready = advance. When advance=0 the whole pipe, skew/deskew registers included, holds. out_valid, sum, cout, ovf and zero stay stable until accepted.
- A bubble (accept not taken) propagates as a cleared valid bit. Data registers may hold don't-care values but outputs still hold while out_valid=0 and the pipe is stalled.
- Throughput: one result per cycle while out_ready=1. Simultaneous accept at the input and drain at the output in the same cycle is legal and loses nothing.
- Wrap-around: sum is modulo 2^N, and cout/ovf report the wrap; no saturation.
- Ignored inputs: values of a, b, cin and sub are ignored when in_valid=0.

Decomposition:
- Shared package add_pkg holds a function for the ovf flag and a localparam derivation CH = N/STAGES, plus the elaboration check N % STAGES == 0.
- One natural sub-module, add_chunk: a registered CH-bit adder slice with carry-in/carry-out and a stage-enable. It is instantiated STAGES times in a generate loop.
- Skew/deskew shift registers stay in the top module.

Test Plan:
- N=16, STAGES=4, out_ready=1: a=1, b=2, cin=0, sub=0 -> sum=3, cout=0, ovf=0, zero=0, out_valid exactly 4 cycles after accept.
- a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> sum=0, cout=1, zero=1, ovf=0 (carry ripples through all 4 chunks). a=16'h7FFF, b=1 -> sum=16'h8000, ovf=1, cout=0.
- Subtract: a=5, b=7, cin=0, sub=1 -> sum=16'hFFFE, cout=0, ovf=0. a=10, b=3, cin=1, sub=1 -> sum=6, cout=1.
- Stream 11 back-to-back ops (a=k, b=k+1, cin=k>5 for k=1..11) -> 11 results in order on consecutive cycles, each equal to a+b+cin.
- Backpressure: hold out_ready=0 for 5 cycles while streaming -> in_ready=0, outputs frozen and stable. On release no result is lost or duplicated, and the order is preserved.
- Assert rst for 1 cycle with 3 ops in flight -> out_valid=0 next cycle, no stale result ever appears. Repeat the first scenario with N=8, STAGES=1 -> latency 1.
